mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single unified instruction/data memory port between two requesters:
//   the core control FSM (port C) and an external loader/debug master (port E).
//   It accepts one access at a time, drives the memory port from registered copies of the
//   request, waits out the fixed memory read latency, and returns read data to the winner.
//   Sits between the core's mem_addr/mem_wren/mem_funct3 mux outputs and the memory macro.
// PARAMETERS
//   ADDR_W  32  address width, in bits, of both requesters and the memory port
//   RD_LAT  1   memory read latency in cycles (legal range 1..4)
// PORTS
//   clk           in   1       clock; all logic is on the rising edge
//   reset         in   1       synchronous, active-high reset
//   c_req         in   1       core request; held with its fields until c_gnt
//   c_addr        in   ADDR_W  core address
//   c_wdata       in   32      core write data
//   c_wren        in   1       1 = write, 0 = read
//   c_funct3      in   3       size/sign code, passed through to memory
//   c_gnt         out  1       1-cycle pulse: core access is being issued to memory
//   c_rvalid      out  1       1-cycle pulse: c_rdata is valid
//   c_rdata       out  32      core read data; held until the next c_rvalid
//   e_req..e_rdata  --  --     same set as the c_* ports, for the external requester
//   mem_addr      out  ADDR_W  memory address
//   mem_wdata     out  32      memory write data
//   mem_wren      out  1       memory write enable
//   mem_funct3    out  3       memory size/sign code
//   mem_rdata     in   32      memory read data, valid RD_LAT cycles after the issue cycle
// BEHAVIOUR
// - Reset, and the cycle after reset: state = IDLE; all outputs = 0; rdata regs = 0; last_gnt = E.
// - States and transitions:
//   - IDLE   -> ISSUE  when any req is sampled.
//   - ISSUE  -> IDLE   on a write.
//   - ISSUE  -> WAIT   on a read.
//   - WAIT   -> IDLE   after RD_LAT cycles.
// - IDLE arbitration:
//   - Only one req high: that requester wins.
//   - Both high: the requester that is not last_gnt wins (round robin). After reset the core wins.
//   - On acceptance: latch addr/wdata/wren/funct3 and the winner ID; update last_gnt.
// - ISSUE (1 cycle):
//   - Drive mem_* from the latched fields.
//   - mem_wren = latched wren; it is high ONLY in this cycle.
//   - Pulse gnt for the winner.
//   - The requester may drop req or change its fields from the next cycle on.
// - WAIT (reads only):
//   - mem_addr and mem_funct3 are held; mem_wren = 0.
//   - Capture mem_rdata at the edge ending cycle ISSUE+RD_LAT.
//   - Pulse the winner's rvalid in the following cycle, the first IDLE cycle.
//   - Hold the winner's rdata; the other port's rdata is unchanged.
// - Latency from req sampled in IDLE (cycle 0):
//   - gnt in cycle 1.
//   - Read: rvalid in cycle RD_LAT+2.
// - Throughput:
//   - Write: one access every 2 cycles.
//   - Read: one access every RD_LAT+2 cycles.
//   - No request is sampled outside IDLE.
// - mem_addr/mem_wdata/mem_funct3 in IDLE: hold their last values; mem_wren = 0.
// - A req dropped before it is accepted is simply not serviced.
// - An accepted access always completes, even if req falls.
// - Simultaneous events:
//   - New reqs arriving during ISSUE/WAIT wait for IDLE.
//   - rvalid and the next acceptance may occur in the same IDLE cycle.
// - Reset mid-operation:
//   - Any in-flight access is abandoned; no gnt/rvalid is produced for it.
//   - A write already issued is not undone.
// - Core FSM integration: the core only advances a memory state after c_gnt/c_rvalid;
//   with e_req held low, the core sees fixed latency.
// TESTING
// - Core read, RD_LAT=2, c_addr=0x100, mem[0x100]=0x12345678 ->
//   c_gnt in cycle 1; mem_addr=0x100 in cycles 1-3; c_rvalid in cycle 4 with c_rdata=0x12345678.
// - c_req and e_req both high out of reset and both held ->
//   grants alternate C,E,C,E; a gnt is never given to both ports in one cycle.
// - E write addr 0x40, data 0xDEADBEEF, funct3=010 ->
//   mem_wren high exactly 1 cycle; a later C read of 0x40 returns 0xDEADBEEF; e_rvalid never pulses.
// - reset pulsed in WAIT of a C read ->
//   next cycle all outputs 0 and no c_rvalid; a subsequent E read completes normally.
// - C drops c_req the cycle after c_gnt -> the read still completes with c_rvalid.
//   C holds c_req for 4 writes -> gnt every 2 cycles.
// - Repeat tests 1 and 3 with RD_LAT=1 and RD_LAT=4 -> rvalid in cycle RD_LAT+2.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port around mem_port_arbiter.
// Handshake: a requester raises *_req with stable fields and holds them until the
// single-cycle *_gnt; read data returns later as a single-cycle *_rvalid with *_rdata.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32);
  logic              c_req;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic              c_wren;
  logic [2:0]        c_funct3;
  logic              c_gnt;
  logic              c_rvalid;
  logic [31:0]       c_rdata;

  logic              e_req;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_wdata;
  logic              e_wren;
  logic [2:0]        e_funct3;
  logic              e_gnt;
  logic              e_rvalid;
  logic [31:0]       e_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wren;
  logic [2:0]        mem_funct3;
  logic [31:0]       mem_rdata;

  logic [1:0]        dbg_state;

  // Arbiter side
  modport slave (
    input  c_req, c_addr, c_wdata, c_wren, c_funct3,
    output c_gnt, c_rvalid, c_rdata,
    input  e_req, e_addr, e_wdata, e_wren, e_funct3,
    output e_gnt, e_rvalid, e_rdata,
    output mem_addr, mem_wdata, mem_wren, mem_funct3,
    input  mem_rdata,
    output dbg_state
  );

  // Requesters and memory side
  modport master (
    output c_req, c_addr, c_wdata, c_wren, c_funct3,
    input  c_gnt, c_rvalid, c_rdata,
    output e_req, e_addr, e_wdata, e_wren, e_funct3,
    input  e_gnt, e_rvalid, e_rdata,
    input  mem_addr, mem_wdata, mem_wren, mem_funct3,
    output mem_rdata,
    input  dbg_state
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the unified instruction/data memory port.
// One access in flight at a time; mem_* are driven from registered copies of the request.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [2:0] LAT3    = 3'(RD_LAT);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              win_e_q, win_e_d;
  logic              last_e_q, last_e_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wren_q, wren_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       c_rdata_q, c_rdata_d;
  logic [31:0]       e_rdata_q, e_rdata_d;
  logic              c_rvalid_q, c_rvalid_d;
  logic              e_rvalid_q, e_rvalid_d;
  logic              pick_e;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_e_d    = win_e_q;
    last_e_d   = last_e_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wren_d     = wren_q;
    funct3_d   = funct3_q;
    c_rdata_d  = c_rdata_q;
    e_rdata_d  = e_rdata_q;
    c_rvalid_d = 1'b0;
    e_rvalid_d = 1'b0;
    // E wins only when alone or when the core had the previous grant
    pick_e     = bus.e_req & (~bus.c_req | ~last_e_q);

    case (state_q)
      S_IDLE: begin
        if (bus.c_req | bus.e_req) begin
          state_d  = S_ISSUE;
          win_e_d  = pick_e;
          last_e_d = pick_e;
          addr_d   = pick_e ? bus.e_addr   : bus.c_addr;
          wdata_d  = pick_e ? bus.e_wdata  : bus.c_wdata;
          wren_d   = pick_e ? bus.e_wren   : bus.c_wren;
          funct3_d = pick_e ? bus.e_funct3 : bus.c_funct3;
        end
      end
      S_ISSUE: begin
        if (wren_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 3'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT3) begin
          state_d = S_IDLE;
          if (win_e_q) begin
            e_rdata_d  = bus.mem_rdata;
            e_rvalid_d = 1'b1;
          end else begin
            c_rdata_d  = bus.mem_rdata;
            c_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      win_e_q    <= 1'b0;
      last_e_q   <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      funct3_q   <= 3'd0;
      c_rdata_q  <= '0;
      e_rdata_q  <= '0;
      c_rvalid_q <= 1'b0;
      e_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_e_q    <= win_e_d;
      last_e_q   <= last_e_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wren_q     <= wren_d;
      funct3_q   <= funct3_d;
      c_rdata_q  <= c_rdata_d;
      e_rdata_q  <= e_rdata_d;
      c_rvalid_q <= c_rvalid_d;
      e_rvalid_q <= e_rvalid_d;
    end
  end

  assign bus.c_gnt      = (state_q == S_ISSUE) & ~win_e_q;
  assign bus.e_gnt      = (state_q == S_ISSUE) &  win_e_q;
  assign bus.c_rvalid   = c_rvalid_q;
  assign bus.e_rvalid   = e_rvalid_q;
  assign bus.c_rdata    = c_rdata_q;
  assign bus.e_rdata    = e_rdata_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_funct3 = funct3_q;
  assign bus.mem_wren   = (state_q == S_ISSUE) & wren_q;
  assign bus.dbg_state  = state_q;
endmodule
